spi_display_rx: RTL and testbench
=================================

Name: spi_display_rx

Overview:
- SPI display receiver: the receiving end of the display link that the video driver transmits on (rst/cs/dc/sclk/mosi).
- Deserialises command and data bytes and tracks SSD1306-style column/page addressing.
- Emits one framebuffer write per data byte.
- Used as an in-fabric display model for bench checking of the video path, and as the display-side front end when a second board acts as the panel.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each asynchronous SPI input (minimum 2).
- COLS, 128, panel columns; column counter width is clog2(COLS).
- PAGES, 8, panel pages of 8 rows each; page counter width is clog2(PAGES).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- spi_rst  input  1  panel reset from transmitter, active low; synchronised, then treated as a synchronous clear.
- spi_cs  input  1  chip select, active low.
- spi_dc  input  1  0 = command byte, 1 = data byte; sampled with the 8th bit.
- spi_sclk  input  1  serial clock, mode 0; sampled on rising edge; max frequency clk/4.
- spi_mosi  input  1  serial data, MSB first.
- fb_we  output  1  one-cycle framebuffer write strobe.
- fb_col  output  7  column of write.
- fb_page  output  3  page of write.
- fb_data  output  8  data byte; bit0 = top row of page.
- display_on  output  1  set by 0xAF, cleared by 0xAE.
- frame_done  output  1  one-cycle pulse when a write wraps from (col_end, page_end) back to (col_start, page_start).

Behaviour:
- Reset values (rst_n low or synchronised spi_rst low):
  - fb_we = 0, fb_col = 0, fb_page = 0, fb_data = 0, display_on = 0, frame_done = 0.
  - col_start = 0, col_end = COLS-1, page_start = 0, page_end = PAGES-1.
  - addr_mode = horizontal; bit count = 0; parser state = IDLE.
- Input synchronisation: cs, dc, sclk and mosi each pass through SYNC_STAGES flops. An sclk rise is detected as synchronised sclk going 0->1. mosi and dc are taken from the same synchronised stage as sclk.
- Deserialiser:
  - Synchronised cs high: bit count = 0, partial byte discarded, parser state kept.
  - On each detected sclk rise with cs low: shift mosi into bit 0, bit count +1.
  - On the 8th bit: the byte is complete with dc latched; bit count returns to 0.
- Latency: fb_we is asserted exactly 1 clk after the cycle that detects the 8th sclk rise.
- Parser states: IDLE, ARG1, ARG2, SKIP.
- Data byte (dc = 1):
  - Accepted in any state; the parser state is unchanged.
  - Outputs fb_we = 1, fb_col = col, fb_page = page, fb_data = byte.
  - Pointer advance, horizontal mode: col+1; at col_end, col = col_start and page+1; at page_end, page = page_start.
  - Pointer advance, vertical mode: page+1; at page_end, page = page_start and col+1; at col_end, col = col_start.
  - frame_done pulses in the same cycle as fb_we for the write at (col_end, page_end).
- Command byte (dc = 0), decoded in IDLE:
  - 0x21: next byte -> col_start and col = col_start (ARG1); following byte -> col_end (ARG2); then IDLE.
  - 0x22: as 0x21, for page_start/page_end/page. Arguments are masked to 3 bits.
  - 0x20: next byte [1:0] sets mode; 00 = horizontal, 01 = vertical, other values leave the mode unchanged. Then IDLE.
  - 0xAE / 0xAF: display_on = 0 / 1.
  - 0x81, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB, 0x8D: consume one argument (SKIP), then IDLE.
  - All other command bytes are ignored and the parser stays in IDLE.
- Argument rules:
  - Argument bytes arrive with dc = 0.
  - A data byte arriving in ARG1, ARG2 or SKIP is written as data, and the parser remains waiting.
- Window boundaries:
  - Argument values are masked to the counter width.
  - If start > end, the counter wraps at COLS-1 (or PAGES-1) to 0 and continues until it reaches end, then reloads start.
- Simultaneous events:
  - If cs deasserts in the same cycle as the 8th bit is detected, the byte completes; the cs clear applies from the next cycle.
  - spi_rst low mid-byte or mid-argument: full clear; no fb_we is issued.

Decomposition:
- Shared package holds:
  - command opcode constants (CMD_COL_ADDR 0x21, CMD_PAGE_ADDR 0x22, CMD_ADDR_MODE 0x20, CMD_DISP_OFF 0xAE, CMD_DISP_ON 0xAF);
  - the one-argument opcode list;
  - the parser state enum;
  - the addressing-mode enum.
- One sub-module: spi_rx_shift, covering synchronisers, edge detect and the 8-bit deserialiser. It outputs a byte, dc and a byte_valid pulse.

Test Plan:
- Reset, then bytes 0x21,0x00,0x7F,0x22,0x00,0x07 (dc=0), then 1024 data bytes -> 1024 fb_we pulses; first write at col 0/page 0; col 127/page 0 then col 0/page 1; single frame_done on the write at 127/7.
- Window 0x21,10,12 and 0x22,2,3, then 7 data bytes -> writes at (10,2),(11,2),(12,2),(10,3),(11,3),(12,3),(10,2) with data matching byte order; frame_done on the 6th write.
- 0x20,0x01 then window 0..1 cols, 0..1 pages, then 4 bytes -> writes at (0,0),(0,1),(1,0),(1,1).
- cs raised after 5 bits, then a full byte 0xA5 with dc=1 -> exactly one fb_we, data 0xA5.
- 0xAF -> display_on = 1; 0x81,0xAE (contrast arg) -> display_on stays 1; 0xAE -> display_on = 0.
- spi_rst pulsed low after 0x21,0x05 -> window restored to 0..127; next data byte written at col 0, page 0.

Source files
------------

// File: rtl/spi_display_rx_pkg.sv
// spi_display_rx_pkg: shared opcodes, parser state and addressing mode types.
package spi_display_rx_pkg;
  localparam logic [7:0] CMD_ADDR_MODE = 8'h20;
  localparam logic [7:0] CMD_COL_ADDR = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR = 8'h22;
  localparam logic [7:0] CMD_DISP_OFF = 8'hAE;
  localparam logic [7:0] CMD_DISP_ON = 8'hAF;
  typedef enum logic [1:0] {IDLE, ARG1, ARG2, SKIP} state_e;
  typedef enum logic {HORIZ, VERT} addr_mode_e;
  // Commands whose single argument byte is consumed without effect.
  function automatic logic is_one_arg(input logic [7:0] b);
    return b inside {8'h81, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D};
  endfunction
endpackage

// File: rtl/spi_rx_shift.sv
// spi_rx_shift: synchronises the SPI pins, detects sclk rises and assembles bytes.
// Ports: clk/rst_n system; spi_* raw pins; clr = synchronised panel reset;
// rx_byte/rx_dc/rx_valid = completed byte, valid for one cycle.
module spi_rx_shift import spi_display_rx_pkg::*; #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_rst,
  input  logic       spi_cs,
  input  logic       spi_dc,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  output logic       clr,
  output logic [7:0] rx_byte,
  output logic       rx_dc,
  output logic       rx_valid
);
  logic [SYNC_STAGES-1:0][4:0] sync_q, sync_d;
  logic [4:0] s;
  logic sclk_prev_q, sclk_prev_d, rise, take;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shreg_q, shreg_d;
  assign s = sync_q[SYNC_STAGES-1];
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {spi_rst, spi_cs, spi_dc, spi_sclk, spi_mosi}};
    clr = ~s[4];
    rise = s[1] & ~sclk_prev_q;
    // The 8th bit still completes if cs rises in the same cycle.
    take = rise & (~s[3] | (bit_cnt_q == 3'd7));
    sclk_prev_d = s[1];
    shreg_d = clr ? '0 : take ? {shreg_q[5:0], s[0]} : shreg_q;
    bit_cnt_d = (clr | (s[3] & ~take)) ? '0 : take ? bit_cnt_q + 3'd1 : bit_cnt_q;
    rx_byte = {shreg_q, s[0]};
    rx_dc = s[2];
    rx_valid = ~clr & take & (bit_cnt_q == 3'd7);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{5'b01000}};
      sclk_prev_q <= 1'b0;
      bit_cnt_q <= '0;
      shreg_q <= '0;
    end else begin
      sync_q <= sync_d;
      sclk_prev_q <= sclk_prev_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q <= shreg_d;
    end
endmodule

// File: rtl/spi_display_rx.sv
// spi_display_rx: SSD1306-style SPI receiver producing framebuffer writes.
// Ports: clk/rst_n system; spi_* link from the video driver;
// fb_we/fb_col/fb_page/fb_data write port; display_on state; frame_done pulse.
module spi_display_rx import spi_display_rx_pkg::*; #(
  parameter int SYNC_STAGES = 2,
  parameter int COLS = 128,
  parameter int PAGES = 8,
  localparam int CW = $clog2(COLS),
  localparam int PW = $clog2(PAGES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spi_rst,
  input  logic          spi_cs,
  input  logic          spi_dc,
  input  logic          spi_sclk,
  input  logic          spi_mosi,
  output logic          fb_we,
  output logic [CW-1:0] fb_col,
  output logic [PW-1:0] fb_page,
  output logic [7:0]    fb_data,
  output logic          display_on,
  output logic          frame_done
);
  logic clr, rx_dc, rx_valid;
  logic [7:0] rx_byte;
  state_e state_q, state_d;
  addr_mode_e mode_q, mode_d;
  logic [7:0] cmd_q, cmd_d;
  logic [CW-1:0] col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
  logic [CW-1:0] fb_col_q, fb_col_d, col_inc, col_adv;
  logic [PW-1:0] page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
  logic [PW-1:0] fb_page_q, fb_page_d, page_inc, page_adv;
  logic [7:0] fb_data_q, fb_data_d;
  logic fb_we_q, fb_we_d, frame_done_q, frame_done_d, display_on_q, display_on_d;
  logic col_wrap, page_wrap;
  spi_rx_shift #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
    .clk(clk), .rst_n(rst_n), .spi_rst(spi_rst), .spi_cs(spi_cs), .spi_dc(spi_dc),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .clr(clr), .rx_byte(rx_byte),
    .rx_dc(rx_dc), .rx_valid(rx_valid)
  );
  always_comb begin
    // Counters run past the panel edge back to 0 so start > end windows wrap.
    col_inc = (col_q == CW'(COLS - 1)) ? '0 : col_q + 1'b1;
    page_inc = (page_q == PW'(PAGES - 1)) ? '0 : page_q + 1'b1;
    col_wrap = col_q == col_end_q;
    page_wrap = page_q == page_end_q;
    col_adv = col_wrap ? col_start_q : col_inc;
    page_adv = page_wrap ? page_start_q : page_inc;
    state_d = state_q;
    mode_d = mode_q;
    cmd_d = cmd_q;
    col_d = col_q;
    page_d = page_q;
    col_start_d = col_start_q;
    col_end_d = col_end_q;
    page_start_d = page_start_q;
    page_end_d = page_end_q;
    fb_we_d = 1'b0;
    fb_col_d = fb_col_q;
    fb_page_d = fb_page_q;
    fb_data_d = fb_data_q;
    frame_done_d = 1'b0;
    display_on_d = display_on_q;
    if (clr) begin
      state_d = IDLE;
      mode_d = HORIZ;
      cmd_d = '0;
      col_d = '0;
      page_d = '0;
      col_start_d = '0;
      col_end_d = CW'(COLS - 1);
      page_start_d = '0;
      page_end_d = PW'(PAGES - 1);
      fb_col_d = '0;
      fb_page_d = '0;
      fb_data_d = '0;
      display_on_d = 1'b0;
    end else if (rx_valid && rx_dc) begin
      fb_we_d = 1'b1;
      fb_col_d = col_q;
      fb_page_d = page_q;
      fb_data_d = rx_byte;
      frame_done_d = col_wrap & page_wrap;
      col_d = (mode_q == HORIZ || page_wrap) ? col_adv : col_q;
      page_d = (mode_q == VERT || col_wrap) ? page_adv : page_q;
    end else if (rx_valid) begin
      case (state_q)
        IDLE: begin
          cmd_d = rx_byte;
          if (rx_byte == CMD_COL_ADDR || rx_byte == CMD_PAGE_ADDR || rx_byte == CMD_ADDR_MODE)
            state_d = ARG1;
          else if (is_one_arg(rx_byte))
            state_d = SKIP;
          else if (rx_byte == CMD_DISP_ON)
            display_on_d = 1'b1;
          else if (rx_byte == CMD_DISP_OFF)
            display_on_d = 1'b0;
        end
        ARG1: begin
          state_d = cmd_q == CMD_ADDR_MODE ? IDLE : ARG2;
          if (cmd_q == CMD_COL_ADDR) begin
            col_start_d = rx_byte[CW-1:0];
            col_d = rx_byte[CW-1:0];
          end else if (cmd_q == CMD_PAGE_ADDR) begin
            page_start_d = rx_byte[PW-1:0];
            page_d = rx_byte[PW-1:0];
          end else if (rx_byte[1:0] == 2'b00)
            mode_d = HORIZ;
          else if (rx_byte[1:0] == 2'b01)
            mode_d = VERT;
        end
        ARG2: begin
          state_d = IDLE;
          col_end_d = cmd_q == CMD_COL_ADDR ? rx_byte[CW-1:0] : col_end_q;
          page_end_d = cmd_q == CMD_PAGE_ADDR ? rx_byte[PW-1:0] : page_end_q;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q <= HORIZ;
      cmd_q <= '0;
      col_q <= '0;
      page_q <= '0;
      col_start_q <= '0;
      col_end_q <= CW'(COLS - 1);
      page_start_q <= '0;
      page_end_q <= PW'(PAGES - 1);
      fb_we_q <= 1'b0;
      fb_col_q <= '0;
      fb_page_q <= '0;
      fb_data_q <= '0;
      frame_done_q <= 1'b0;
      display_on_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      cmd_q <= cmd_d;
      col_q <= col_d;
      page_q <= page_d;
      col_start_q <= col_start_d;
      col_end_q <= col_end_d;
      page_start_q <= page_start_d;
      page_end_q <= page_end_d;
      fb_we_q <= fb_we_d;
      fb_col_q <= fb_col_d;
      fb_page_q <= fb_page_d;
      fb_data_q <= fb_data_d;
      frame_done_q <= frame_done_d;
      display_on_q <= display_on_d;
    end
  assign fb_we = fb_we_q;
  assign fb_col = fb_col_q;
  assign fb_page = fb_page_q;
  assign fb_data = fb_data_q;
  assign frame_done = frame_done_q;
  assign display_on = display_on_q;
endmodule

// File: tb/tb_spi_display_rx.sv
// tb_spi_display_rx: scoreboard bench driving SPI bytes and checking framebuffer writes.
module tb_spi_display_rx;
  logic clk = 0, rst_n, spi_rst, spi_cs, spi_dc, spi_sclk, spi_mosi;
  logic fb_we, display_on, frame_done;
  logic [6:0] fb_col;
  logic [2:0] fb_page;
  logic [7:0] fb_data;
  typedef struct packed {logic [6:0] col; logic [2:0] page; logic [7:0] data; logic fd;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  spi_display_rx dut (
    .clk(clk), .rst_n(rst_n), .spi_rst(spi_rst), .spi_cs(spi_cs), .spi_dc(spi_dc),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .fb_we(fb_we), .fb_col(fb_col),
    .fb_page(fb_page), .fb_data(fb_data), .display_on(display_on), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    exp_t e;
    if (fb_we) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write col=%0d page=%0d data=%h", fb_col, fb_page, fb_data);
      end else begin
        e = sb.pop_front();
        if ({fb_col, fb_page, fb_data, frame_done} !== e) begin
          bad++;
          $display("FAIL write got col=%0d page=%0d data=%h fd=%b exp col=%0d page=%0d data=%h fd=%b",
                   fb_col, fb_page, fb_data, frame_done, e.col, e.page, e.data, e.fd);
        end
      end
    end else if (frame_done) begin
      total++;
      bad++;
      $display("FAIL stray_frame_done got=1 exp=0");
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic send_bits(input logic [7:0] b, input logic dc, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk);
      spi_mosi = b[i];
      spi_dc = dc;
      spi_sclk = 0;
      repeat (2) @(negedge clk);
      spi_sclk = 1;
      repeat (2) @(negedge clk);
    end
    spi_sclk = 0;
  endtask
  task automatic cmd(input logic [7:0] b);
    send_bits(b, 0, 8);
  endtask
  task automatic data(input logic [7:0] b, input int c, input int p, input logic fd);
    sb.push_back({7'(c), 3'(p), b, fd});
    send_bits(b, 1, 8);
  endtask
  initial begin
    int c3[7] = '{10, 11, 12, 10, 11, 12, 10};
    int p3[7] = '{2, 2, 2, 3, 3, 3, 2};
    rst_n = 0; spi_rst = 1; spi_cs = 1; spi_dc = 0; spi_sclk = 0; spi_mosi = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("rst_fb_we", fb_we, 0);
    chk("rst_fb_col", fb_col, 0);
    chk("rst_fb_page", fb_page, 0);
    chk("rst_fb_data", fb_data, 0);
    chk("rst_display_on", display_on, 0);
    chk("rst_frame_done", frame_done, 0);
    repeat (6) @(negedge clk);
    spi_cs = 0;
    cmd(8'h21); cmd(8'h00); cmd(8'h7F); cmd(8'h22); cmd(8'h00); cmd(8'h07);
    for (int i = 0; i < 1024; i++) data(8'(i), i % 128, i / 128, i == 1023);
    cmd(8'h21); cmd(8'd10); cmd(8'd12); cmd(8'h22); cmd(8'd2); cmd(8'd3);
    for (int k = 0; k < 7; k++) data(8'h30 + 8'(k), c3[k], p3[k], k == 5);
    cmd(8'h20); cmd(8'h01); cmd(8'h21); cmd(8'h00); cmd(8'h01); cmd(8'h22); cmd(8'h00); cmd(8'h01);
    data(8'hC0, 0, 0, 0); data(8'hC1, 0, 1, 0); data(8'hC2, 1, 0, 0); data(8'hC3, 1, 1, 1);
    send_bits(8'hFF, 1, 5);
    spi_cs = 1;
    repeat (6) @(negedge clk);
    spi_cs = 0;
    data(8'hA5, 0, 0, 0);
    cmd(8'hAF);
    repeat (8) @(negedge clk);
    chk("display_on_af", display_on, 1);
    cmd(8'h81); cmd(8'hAE);
    repeat (8) @(negedge clk);
    chk("display_on_contrast_arg", display_on, 1);
    cmd(8'hAE);
    repeat (8) @(negedge clk);
    chk("display_off_ae", display_on, 0);
    cmd(8'hAF);
    cmd(8'h21); cmd(8'h05);
    send_bits(8'hFF, 1, 4);
    spi_rst = 0;
    repeat (6) @(negedge clk);
    chk("spi_rst_fb_data", fb_data, 0);
    chk("spi_rst_display_on", display_on, 0);
    spi_rst = 1;
    repeat (6) @(negedge clk);
    data(8'h3C, 0, 0, 0);
    data(8'h3D, 1, 0, 0);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("queue_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
